// File: rtl/cic_pkg.sv
// Shared defaults, scheduler state type and decimation-select clamp for the
// CIC readout scheduler.
package cic_pkg;

  localparam int unsigned NUM_CH_DEF         = 4;
  localparam int unsigned DATA_WIDTH_DEF     = 25;
  localparam int unsigned MAX_LOG2_DECIM_DEF = 8;
  localparam int unsigned DECIM_SEL_W        = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sched_state_t;

  // A zero request would give a period of 1, which leaves no cycle to drain.
  function automatic int unsigned clamp_log2(input int unsigned sel,
                                             input int unsigned max_log2);
    if (sel == 0) begin
      return 1;
    end else if (sel > max_log2) begin
      return max_log2;
    end else begin
      return sel;
    end
  endfunction

endpackage

// File: rtl/cic_pending_select.sv
// Lowest-index priority select over the pending readout mask, with
// one-remaining detection for end-of-frame marking.
module cic_pending_select #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2
) (
  input  logic [NUM_CH-1:0] pending,
  output logic              any,
  output logic [CH_W-1:0]   sel_idx,
  output logic [NUM_CH-1:0] sel_onehot,
  output logic              last
);

  logic found;

  always_comb begin
    found      = 1'b0;
    sel_idx    = '0;
    sel_onehot = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (pending[i] && !found) begin
        found         = 1'b1;
        sel_idx       = CH_W'(i);
        sel_onehot[i] = 1'b1;
      end
    end
  end

  assign any  = |pending;
  assign last = any && ((pending & (pending - NUM_CH'(1))) == '0);

endmodule

// File: rtl/cic_readout_sched.sv
// Decimation timing and per-channel readout scheduler for a bank of CIC
// filters: generates the comb-stage strobe and serialises captured words.
module cic_readout_sched
  import cic_pkg::*;
#(
  parameter int unsigned NUM_CH         = NUM_CH_DEF,
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int unsigned MAX_LOG2_DECIM = MAX_LOG2_DECIM_DEF,
  localparam int unsigned CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [DECIM_SEL_W-1:0]       decim_sel,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  output logic                         sample_tick,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_last,
  output logic                         overrun,
  input  logic                         overrun_clr
);

  localparam int unsigned ACT_W = $clog2(MAX_LOG2_DECIM + 1);
  localparam int unsigned CNT_W = MAX_LOG2_DECIM;

  sched_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [ACT_W-1:0]      act_q;
  logic [ACT_W-1:0]      act_sel;
  logic [CNT_W-1:0]      period_m1;
  logic [NUM_CH-1:0]     pending_q;
  logic [NUM_CH-1:0]     pending_after;
  logic [NUM_CH-1:0]     sel_onehot;
  logic [NUM_CH-1:0]     accept_mask;
  logic [DATA_WIDTH-1:0] hold_q [NUM_CH];
  logic                  overrun_q;
  logic                  tick;
  logic                  capture;
  logic                  any_pending;
  logic                  last_pending;
  logic [CH_W-1:0]       sel_idx;

  cic_pending_select #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_select (
    .pending    (pending_q),
    .any        (any_pending),
    .sel_idx    (sel_idx),
    .sel_onehot (sel_onehot),
    .last       (last_pending)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    act_sel       = ACT_W'(clamp_log2(32'(decim_sel), MAX_LOG2_DECIM));
    period_m1     = CNT_W'((32'd1 << act_q) - 32'd1);
    tick          = (state_q == RUN) && (cnt_q == period_m1);
    capture       = tick && enable;
    accept_mask   = sel_onehot & {NUM_CH{any_pending && out_ready}};
    pending_after = pending_q & ~accept_mask;
  end

  // A capture replaces whatever is still pending; that loss is what overrun records.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      act_q     <= ACT_W'(1);
      pending_q <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        hold_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        cnt_q     <= '0;
        pending_q <= '0;
        if (enable) begin
          act_q <= act_sel;
        end
      end else if (!enable) begin
        cnt_q     <= '0;
        pending_q <= '0;
      end else if (tick) begin
        cnt_q     <= '0;
        act_q     <= act_sel;
        pending_q <= ch_enable;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          hold_q[i] <= ch_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end else begin
        cnt_q     <= cnt_q + CNT_W'(1);
        pending_q <= pending_after;
      end

      if (capture && (|pending_after)) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

  assign sample_tick = tick;
  assign out_valid   = any_pending;
  assign out_ch      = sel_idx;
  assign out_data    = hold_q[sel_idx];
  assign out_last    = last_pending;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_cic_readout_sched.sv
// Scoreboard bench for cic_readout_sched: stimulus queues expected ticks and
// beats, a negedge monitor pops and compares them.
module tb_cic_readout_sched;
  import cic_pkg::*;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 25;

  logic              clk = 1'b0;
  logic              reset, enable, out_ready, overrun_clr;
  logic [3:0]        decim_sel;
  logic [NCH-1:0]    ch_enable;
  logic [NCH*DW-1:0] ch_data;
  logic              sample_tick, out_valid, out_last, overrun;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_ch;

  cic_readout_sched #(
    .NUM_CH         (NCH),
    .DATA_WIDTH     (DW),
    .MAX_LOG2_DECIM (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .decim_sel   (decim_sel),
    .ch_enable   (ch_enable),
    .ch_data     (ch_data),
    .sample_tick (sample_tick),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ch      (out_ch),
    .out_last    (out_last),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int            cyc;
    logic [1:0]    ch;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t beat_q[$];
  int    tick_q[$];
  beat_t b;
  int    e;

  always @(negedge clk) begin
    if (sample_tick) begin
      n_vec++;
      if (tick_q.size() == 0) begin
        n_bad++;
        $display("FAIL tick_unexpected got cyc=%0d required none", cyc);
      end else begin
        e = tick_q.pop_front();
        if (e != cyc) begin
          n_bad++;
          $display("FAIL tick_cycle got=%0d required=%0d", cyc, e);
        end
      end
    end
    if (out_valid && out_ready) begin
      n_vec++;
      if (beat_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat_unexpected got cyc=%0d ch=%0d data=%h", cyc, out_ch, out_data);
      end else begin
        b = beat_q.pop_front();
        if (b.cyc != cyc || b.ch !== out_ch || b.data !== out_data || b.last !== out_last) begin
          n_bad++;
          $display("FAIL beat got cyc=%0d ch=%0d data=%h last=%b required cyc=%0d ch=%0d data=%h last=%b",
                   cyc, out_ch, out_data, out_last, b.cyc, b.ch, b.data, b.last);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic drain(input string name);
    chk({name, "_ticks_missing"}, tick_q.size(), 0);
    chk({name, "_beats_missing"}, beat_q.size(), 0);
  endtask

  task automatic push_beat(input int c, input logic [1:0] ch, input logic [DW-1:0] d, input logic l);
    beat_t nb;
    nb.cyc  = c;
    nb.ch   = ch;
    nb.data = d;
    nb.last = l;
    beat_q.push_back(nb);
  endtask

  function automatic logic [NCH*DW-1:0] pack(input logic [DW-1:0] a, input logic [DW-1:0] b1,
                                             input logic [DW-1:0] c, input logic [DW-1:0] d);
    return {d, c, b1, a};
  endfunction

  task automatic reset_outputs_zero(input string name);
    chk({name, "_valid"},   out_valid,   0);
    chk({name, "_tick"},    sample_tick, 0);
    chk({name, "_data"},    out_data,    0);
    chk({name, "_ch"},      out_ch,      0);
    chk({name, "_last"},    out_last,    0);
    chk({name, "_overrun"}, overrun,     0);
  endtask

  int c;

  initial begin
    reset = 1'b1; enable = 1'b0; out_ready = 1'b0; overrun_clr = 1'b0;
    decim_sel = '0; ch_enable = '0; ch_data = '0;
    step();
    step();
    reset_outputs_zero("reset");

    // Period 4 from reset release, no channels enabled
    c = cyc;
    reset = 1'b0; decim_sel = 4'd2; enable = 1'b1;
    tick_q.push_back(c + 4); tick_q.push_back(c + 8); tick_q.push_back(c + 12);
    wait_to(c + 13);
    enable = 1'b0;
    wait_to(c + 14);
    chk("a_idle_valid", out_valid, 0);
    chk("a_no_overrun", overrun, 0);
    wait_to(c + 16);
    drain("a");

    // Channels 0,1,3 back-to-back, last on channel 3
    c = cyc;
    decim_sel = 4'd2; ch_enable = 4'b1011; out_ready = 1'b1; enable = 1'b1;
    ch_data = pack(25'h0ABCDE, 25'h1234567, 25'h0FFFFF, 25'h1000001);
    tick_q.push_back(c + 4); tick_q.push_back(c + 8);
    push_beat(c + 5, 2'd0, 25'h0ABCDE, 1'b0);
    push_beat(c + 6, 2'd1, 25'h1234567, 1'b0);
    push_beat(c + 7, 2'd3, 25'h1000001, 1'b1);
    wait_to(c + 5);
    ch_enable = '0;
    ch_data = pack(25'h1111111, 25'h0222222, 25'h0333333, 25'h0444444);
    wait_to(c + 9);
    enable = 1'b0;
    wait_to(c + 11);
    drain("b");

    // Period 2, no ready: overrun, second capture replaces first
    c = cyc;
    decim_sel = 4'd1; ch_enable = 4'b0100; out_ready = 1'b0; enable = 1'b1;
    ch_data = pack(25'h0000011, 25'h0000022, 25'h0000033, 25'h0000044);
    tick_q.push_back(c + 2); tick_q.push_back(c + 4);
    tick_q.push_back(c + 6); tick_q.push_back(c + 8);
    wait_to(c + 3);
    chk("c_valid", out_valid, 1);
    chk("c_ch", out_ch, 2);
    chk("c_data1", out_data, 25'h0000033);
    chk("c_no_overrun_yet", overrun, 0);
    ch_data = pack(25'h1500011, 25'h1500022, 25'h1500033, 25'h1500044);
    wait_to(c + 4);
    chk("c_data_stable", out_data, 25'h0000033);
    overrun_clr = 1'b1;
    wait_to(c + 5);
    overrun_clr = 1'b0;
    chk("c_overrun_set_wins", overrun, 1);
    chk("c_data2", out_data, 25'h1500033);
    chk("c_last", out_last, 1);
    ch_enable = '0; out_ready = 1'b1;
    push_beat(c + 5, 2'd2, 25'h1500033, 1'b1);
    wait_to(c + 7);
    chk("c_overrun_sticky", overrun, 1);
    overrun_clr = 1'b1;
    wait_to(c + 8);
    overrun_clr = 1'b0;
    chk("c_overrun_cleared", overrun, 0);
    wait_to(c + 9);
    enable = 1'b0;
    wait_to(c + 11);
    drain("c");

    // Last beat accepted in the tick cycle: no overrun
    c = cyc;
    decim_sel = 4'd1; ch_enable = 4'b0011; out_ready = 1'b1; enable = 1'b1;
    ch_data = pack(25'h0C0FFEE, 25'h0BEEF00, 25'h0, 25'h0);
    tick_q.push_back(c + 2); tick_q.push_back(c + 4); tick_q.push_back(c + 6);
    push_beat(c + 3, 2'd0, 25'h0C0FFEE, 1'b0);
    push_beat(c + 4, 2'd1, 25'h0BEEF00, 1'b1);
    push_beat(c + 5, 2'd0, 25'h0C0FFEE, 1'b0);
    push_beat(c + 6, 2'd1, 25'h0BEEF00, 1'b1);
    wait_to(c + 5);
    ch_enable = '0;
    wait_to(c + 7);
    chk("h_no_overrun", overrun, 0);
    enable = 1'b0;
    wait_to(c + 9);
    drain("h");

    // decim_sel 3 -> 5 mid-period
    c = cyc;
    decim_sel = 4'd3; enable = 1'b1; out_ready = 1'b0;
    tick_q.push_back(c + 8); tick_q.push_back(c + 40);
    wait_to(c + 3);
    decim_sel = 4'd5;
    wait_to(c + 41);
    enable = 1'b0;
    wait_to(c + 43);
    drain("d");

    // Clamp: 0 -> period 2, 15 -> period 256
    c = cyc;
    decim_sel = 4'd0; enable = 1'b1;
    tick_q.push_back(c + 2); tick_q.push_back(c + 4);
    wait_to(c + 5);
    enable = 1'b0;
    wait_to(c + 7);
    drain("e0");
    c = cyc;
    decim_sel = 4'd15; enable = 1'b1;
    tick_q.push_back(c + 256);
    wait_to(c + 257);
    enable = 1'b0;
    wait_to(c + 259);
    drain("e15");

    // Enable dropped mid-frame, then a full period before the next tick
    c = cyc;
    decim_sel = 4'd2; ch_enable = 4'b1111; out_ready = 1'b0; enable = 1'b1;
    ch_data = pack(25'h0000A0, 25'h0000A1, 25'h0000A2, 25'h0000A3);
    tick_q.push_back(c + 4); tick_q.push_back(c + 10);
    wait_to(c + 5);
    chk("f_valid_before_drop", out_valid, 1);
    enable = 1'b0;
    wait_to(c + 6);
    chk("f_valid_after_drop", out_valid, 0);
    chk("f_tick_after_drop", sample_tick, 0);
    enable = 1'b1; out_ready = 1'b1; ch_enable = 4'b0001;
    ch_data = pack(25'h00B0B0, 25'h0, 25'h0, 25'h0);
    push_beat(c + 11, 2'd0, 25'h00B0B0, 1'b1);
    wait_to(c + 12);
    enable = 1'b0; ch_enable = '0;
    wait_to(c + 14);
    drain("f");

    // Reset mid-frame with overrun set
    c = cyc;
    decim_sel = 4'd1; ch_enable = 4'b0011; out_ready = 1'b0; enable = 1'b1;
    ch_data = pack(25'h0DEAD0, 25'h0DEAD1, 25'h0, 25'h0);
    tick_q.push_back(c + 2); tick_q.push_back(c + 4); tick_q.push_back(c + 8);
    wait_to(c + 5);
    chk("g_overrun_before_reset", overrun, 1);
    chk("g_valid_before_reset", out_valid, 1);
    reset = 1'b1;
    wait_to(c + 6);
    reset_outputs_zero("g_after_reset");
    reset = 1'b0; ch_enable = '0;
    wait_to(c + 9);
    enable = 1'b0;
    wait_to(c + 11);
    drain("g");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_readout_sched.md
CIC_READOUT_SCHED -- requirements
Module: cic_readout_sched

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of CIC datapaths served.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 25, giving the width of each CIC output word (3*8+1).
REQ-003 The block SHALL have parameter MAX_LOG2_DECIM, default 8, giving the largest log2 decimation factor supported.
REQ-004 Port clk  input  1  SHALL be the single modulator-rate clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  SHALL be the synchronous, active-high reset.
REQ-006 Port enable  input  1  SHALL be the run/stop control for decimation timing.
REQ-007 Port decim_sel  input  4  SHALL be the requested log2 decimation factor.
REQ-008 Port ch_enable  input  NUM_CH  SHALL be the per-channel readout enable.
REQ-009 Port ch_data  input  NUM_CH x DATA_WIDTH  SHALL be the CIC comb outputs, one word per channel.
REQ-010 Port sample_tick  output  1  SHALL be the one-cycle decimated-rate strobe that drives the CIC comb stages.
REQ-011 Ports out_valid/out_ready  output/input  1/1  SHALL form the readout handshake.
REQ-012 Ports out_data/out_ch/out_last  output  DATA_WIDTH/clog2(NUM_CH)/1  SHALL carry the sample, its channel index and an end-of-frame flag.
REQ-013 Ports overrun  output  1  and overrun_clr  input  1  SHALL report and clear a sticky overrun flag.

Function
REQ-014 The FSM SHALL have two states, IDLE and RUN: IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-015 The active period SHALL be 2^act_log2, with act_log2 = decim_sel clamped to 1..MAX_LOG2_DECIM (0->1, >MAX->MAX).
REQ-016 act_log2 SHALL be latched on the IDLE->RUN transition and at every counter wrap, and at no other time.
REQ-017 The period counter SHALL be 0 in the first RUN cycle, increment by 1 per cycle and wrap to 0 after period-1.
REQ-018 sample_tick SHALL be 1 exactly in RUN cycles where counter == period-1, and 0 otherwise.
REQ-019 On the edge ending a tick cycle, the block SHALL load hold registers from ch_data and set pending = ch_enable.
REQ-020 The output signals SHALL be driven as follows: out_valid = |pending; out_ch = lowest-index pending channel; out_data = that channel's hold word; out_last = 1 when exactly one pending bit remains.
REQ-021 out_valid && out_ready SHALL clear the presented pending bit, so the next channel is presented in the following cycle with no bubble.
REQ-022 While out_valid=1 and not accepted, out_data and out_ch SHALL remain stable, except on a capture edge or when leaving RUN.
REQ-023 The overrun flag SHALL be set on a capture edge where pending bits remain after that cycle's handshake.
REQ-024 On overrun, the unsent samples SHALL be dropped and replaced by the new capture.
REQ-025 If the last pending bit is accepted in the tick cycle itself, overrun SHALL NOT be set.
REQ-026 overrun SHALL stay set until overrun_clr=1; if set and clear occur in the same cycle, set SHALL win.
REQ-027 A capture with ch_enable=0 SHALL produce no output and no overrun.
REQ-028 In IDLE, the counter and pending SHALL be held at 0 (out_valid=0 and sample_tick=0 from the first IDLE cycle), and overrun SHALL be held.

Reset
REQ-029 While reset=1, the block SHALL force state=IDLE, counter=0, act_log2=1, pending=0, hold registers=0 and overrun=0.
REQ-030 As a consequence, all outputs SHALL read 0 in the cycle after reset is sampled.
REQ-031 Reset asserted during RUN or mid-frame SHALL abort the frame with no further handshake.

Structure
REQ-032 Package cic_pkg SHALL hold NUM_CH, DATA_WIDTH and MAX_LOG2_DECIM defaults, the decim_sel width, and the IDLE/RUN state enum type.
REQ-033 Sub-module cic_pending_select SHALL implement the lowest-index pending priority encoder and the one-hot/last-bit detection.

Verification
REQ-034 Bench SHALL check: decim_sel=2, enable from cycle 0 -> sample_tick exactly at RUN cycles 3, 7, 11.
REQ-035 Bench SHALL check: ch_enable=4'b1011, out_ready=1 -> channels 0, 1, 3 in three consecutive cycles, out_last only with channel 3.
REQ-036 Bench SHALL check: decim_sel=1, out_ready=0 -> overrun=1 after the second tick, and out_data equals the second capture.
REQ-037 Bench SHALL check: decim_sel changed 3->5 mid-period -> the current period still ends after 8 cycles and the next period lasts 32 cycles.
REQ-038 Bench SHALL check: decim_sel=0 -> period 2; decim_sel=15 -> period 256.
REQ-039 Bench SHALL check: enable or reset dropped while out_valid=1 -> out_valid=0 the next cycle; on re-enable the first tick comes after a full period.
